// File: rtl/step_input_pkg.sv
// step_input_pkg: shared state encoding for button step conditioning
package step_input_pkg;
    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        PRESS_CHECK   = 2'd1,
        PRESSED       = 2'd2,
        RELEASE_CHECK = 2'd3
    } state_t;
endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain: multi-flop synchroniser for an asynchronous input
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;
    always_ff @(posedge clk) r <= rst ? '0 : {r[STAGES-2:0], d};
    assign q = r[STAGES-1];
endmodule

// File: rtl/button_step_debouncer.sv
// button_step_debouncer: debounced button level, press/repeat step pulses and release pulse
module button_step_debouncer
    import step_input_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic step,
    output logic release_pulse
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    state_t        state;
    logic          btn_s;
    logic          armed;
    logic [DW-1:0] deb_cnt;
    logic [RW-1:0] rep_cnt;
    logic          deb_done;
    logic          rep_hit;
    logic [RW-1:0] rep_tgt;
    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_in),
        .q  (btn_s)
    );
    // rep_cnt counts cycles since PRESSED entry or the last repeat step
    assign rep_tgt  = armed ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
    assign rep_hit  = REPEAT_DELAY != 0 && rep_cnt + RW'(1) == rep_tgt;
    assign deb_done = deb_cnt == DW'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RELEASED;
            deb_cnt       <= '0;
            rep_cnt       <= '0;
            armed         <= 1'b0;
            btn_level     <= 1'b0;
            step          <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            step          <= 1'b0;
            release_pulse <= 1'b0;
            case (state)
                RELEASED: if (btn_s) begin
                    state   <= PRESS_CHECK;
                    deb_cnt <= '0;
                end
                PRESS_CHECK: if (!btn_s) state <= RELEASED;
                else if (deb_done) begin
                    state     <= PRESSED;
                    rep_cnt   <= '0;
                    armed     <= 1'b0;
                    btn_level <= 1'b1;
                    step      <= 1'b1;
                end else deb_cnt <= deb_cnt + DW'(1);
                PRESSED: if (!btn_s) begin
                    state   <= RELEASE_CHECK;
                    deb_cnt <= '0;
                end else if (rep_hit) begin
                    step    <= 1'b1;
                    rep_cnt <= '0;
                    armed   <= 1'b1;
                end else if (REPEAT_DELAY != 0) rep_cnt <= rep_cnt + RW'(1);
                RELEASE_CHECK: if (btn_s) state <= PRESSED;
                else if (deb_done) begin
                    state         <= RELEASED;
                    btn_level     <= 1'b0;
                    release_pulse <= 1'b1;
                end else deb_cnt <= deb_cnt + DW'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_button_step_debouncer.sv
// tb_button_step_debouncer: directed checks of press, bounce, repeat, glitch, release and reset
module tb_button_step_debouncer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_a = 1'b0;
    logic btn_b = 1'b0;
    logic level_a, step_a, rel_a;
    logic level_b, step_b, rel_b;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    button_step_debouncer #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_a),
        .btn_level(level_a), .step(step_a), .release_pulse(rel_a)
    );

    button_step_debouncer #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_b),
        .btn_level(level_b), .step(step_b), .release_pulse(rel_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt_s, cnt_r;
        edges(2);
        check("rst_level_a", level_a, 0);
        check("rst_step_a", step_a, 0);
        check("rst_rel_a", rel_a, 0);
        check("rst_level_b", level_b, 0);
        rst = 1'b0;
        edges(3);

        // clean press on A, then hold: PRESSED index k is seen after edge 7+k
        btn_a = 1'b1;
        edges(6);
        check("press_early_step", step_a, 0);
        check("press_early_level", level_a, 0);
        edges(1);
        check("press_step", step_a, 1);
        check("press_level", level_a, 1);
        for (int k = 1; k <= 25; k++) begin
            edges(1);
            check("hold_step", step_a,
                  (k == 8 || k == 11 || k == 14 || k == 17 || k == 20 || k == 23) ? 1 : 0);
            check("hold_level", level_a, 1);
        end

        // release A at index 25; index 26 is still a due repeat
        btn_a = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            edges(1);
            check("rel_a_level", level_a, j < 7 ? 1 : 0);
            check("rel_a_pulse", rel_a, j == 7 ? 1 : 0);
            check("rel_a_step", step_a, j == 1 ? 1 : 0);
        end

        // B: no auto-repeat, exactly one step over a long hold
        btn_b = 1'b1;
        edges(7);
        check("b_press_step", step_b, 1);
        cnt_s = 0;
        for (int j = 0; j < 50; j++) begin
            edges(1);
            cnt_s += int'(step_b);
        end
        check("b_hold_no_repeat", cnt_s, 0);

        // B: two-cycle low glitch is rejected
        btn_b = 1'b0;
        edges(2);
        btn_b = 1'b1;
        cnt_s = 0;
        cnt_r = 0;
        for (int j = 0; j < 10; j++) begin
            check("glitch_level", level_b, 1);
            cnt_s += int'(step_b);
            cnt_r += int'(rel_b);
            edges(1);
        end
        check("glitch_no_step", cnt_s, 0);
        check("glitch_no_rel", cnt_r, 0);

        btn_b = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            edges(1);
            check("rel_b_level", level_b, j < 7 ? 1 : 0);
            check("rel_b_pulse", rel_b, j == 7 ? 1 : 0);
        end

        // A: bounce, high edges 1-3, low edge 4, high after
        edges(3);
        for (int j = 1; j <= 14; j++) begin
            btn_a = (j == 4) ? 1'b0 : 1'b1;
            edges(1);
            check("bounce_step", step_a, j == 11 ? 1 : 0);
            check("bounce_level", level_a, j >= 11 ? 1 : 0);
        end

        // reset while PRESSED with button still held
        rst = 1'b1;
        edges(1);
        check("mid_rst_level", level_a, 0);
        check("mid_rst_step", step_a, 0);
        check("mid_rst_rel", rel_a, 0);
        rst = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            edges(1);
            check("post_rst_step", step_a, j == 7 ? 1 : 0);
            check("post_rst_level", level_a, j >= 7 ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
